// File: rtl/seq_chunk_adder.sv
// Multi-cycle adder: sum = a + b + cin over WIDTH bits, CHUNK bits per clock, LSB chunk first.
// Optional signed-overflow output is built when SEQ_ADD_OVF_EN is defined.
module seq_chunk_adder #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef SEQ_ADD_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    // Handshake: start is accepted only while busy=0 (request valid, !busy is ready);
    // busy stays high for NCHUNK cycles, then done pulses one cycle with sum/cout valid.
    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t state;
    state_t state_n;

    logic             load;
    logic             step;
    logic             last_step;
    logic             last;

    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] acc_n;
    logic             carry;
    logic [IDXW-1:0]  idx;

    logic [CHUNK-1:0] ca;
    logic [CHUNK-1:0] cb;
    logic [CHUNK:0]   csum;

    assign busy = (state == RUN);
    assign last = (idx == IDXW'(NCHUNK - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n   = state;
        load      = 1'b0;
        step      = 1'b0;
        last_step = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    load    = 1'b1;
                    state_n = RUN;
                end
            end
            RUN: begin
                step = 1'b1;
                if (last) begin
                    last_step = 1'b1;
                    state_n   = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Chunk select and write-back use constant slices so the per-cycle carry chain stays CHUNK bits.
    always_comb begin
        ca    = '0;
        cb    = '0;
        acc_n = acc;
        for (int i = 0; i < NCHUNK; i++) begin
            if (idx == IDXW'(i)) begin
                ca = a_q[i*CHUNK +: CHUNK];
                cb = b_q[i*CHUNK +: CHUNK];
            end
        end
        csum = {1'b0, ca} + {1'b0, cb} + {{CHUNK{1'b0}}, carry};
        for (int i = 0; i < NCHUNK; i++) begin
            if (idx == IDXW'(i)) begin
                acc_n[i*CHUNK +: CHUNK] = csum[CHUNK-1:0];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q   <= '0;
            b_q   <= '0;
            acc   <= '0;
            carry <= 1'b0;
            idx   <= '0;
            done  <= 1'b0;
            sum   <= '0;
            cout  <= 1'b0;
        end else begin
            done <= last_step;
            if (load) begin
                a_q   <= a;
                b_q   <= b;
                carry <= cin;
                idx   <= '0;
                acc   <= '0;
            end else if (step) begin
                acc   <= acc_n;
                carry <= csum[CHUNK];
                idx   <= last ? '0 : idx + 1'b1;
            end
            // Results move only on completion so they hold through RUN and IDLE.
            if (last_step) begin
                sum  <= acc_n;
                cout <= csum[CHUNK];
            end
        end
    end

`ifdef SEQ_ADD_OVF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf <= 1'b0;
        end else if (last_step) begin
            ovf <= (a_q[WIDTH-1] == b_q[WIDTH-1]) && (acc_n[WIDTH-1] != a_q[WIDTH-1]);
        end
    end
`endif

endmodule

// File: tb/tb_seq_chunk_adder.sv
// Bench for seq_chunk_adder: 16/4 directed vector table, handshake and reset sequences,
// plus exhaustive 4-bit sweeps with CHUNK=4 and CHUNK=1.
module tb_seq_chunk_adder;

    logic        clk;
    logic        rst_n;

    logic        start16;
    logic [15:0] a16;
    logic [15:0] b16;
    logic        cin16;
    logic        busy16;
    logic        done16;
    logic [15:0] sum16;
    logic        cout16;

    logic        start4;
    logic [3:0]  a4;
    logic [3:0]  b4;
    logic        cin4;
    logic        busy4a;
    logic        done4a;
    logic [3:0]  sum4a;
    logic        cout4a;
    logic        busy4b;
    logic        done4b;
    logic [3:0]  sum4b;
    logic        cout4b;

`ifdef SEQ_ADD_OVF_EN
    logic        ovf16;
    logic        ovf4a;
    logic        ovf4b;
`endif

    int tests;
    int failed;

    logic [16:0] exp_q[$];
    logic [15:0] last_sum;
    logic        last_cout;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic [15:0] s;
        logic        co;
        logic        ov;
    } vec_t;

    localparam int NV = 9;
    vec_t vecs[NV];

    seq_chunk_adder #(.WIDTH(16), .CHUNK(4)) u16 (
        .clk(clk), .rst_n(rst_n), .start(start16), .a(a16), .b(b16), .cin(cin16),
        .busy(busy16), .done(done16), .sum(sum16), .cout(cout16)
`ifdef SEQ_ADD_OVF_EN
        , .ovf(ovf16)
`endif
    );

    seq_chunk_adder #(.WIDTH(4), .CHUNK(4)) u4a (
        .clk(clk), .rst_n(rst_n), .start(start4), .a(a4), .b(b4), .cin(cin4),
        .busy(busy4a), .done(done4a), .sum(sum4a), .cout(cout4a)
`ifdef SEQ_ADD_OVF_EN
        , .ovf(ovf4a)
`endif
    );

    seq_chunk_adder #(.WIDTH(4), .CHUNK(1)) u4b (
        .clk(clk), .rst_n(rst_n), .start(start4), .a(a4), .b(b4), .cin(cin4),
        .busy(busy4b), .done(done4b), .sum(sum4b), .cout(cout4b)
`ifdef SEQ_ADD_OVF_EN
        , .ovf(ovf4b)
`endif
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", tests, failed + 1);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Wait for done16 within a cycle budget; returns cycles counted from the accepting edge.
    task automatic wait_done16(output int cyc, output logic seen, output logic held, output logic overlap);
        cyc = 0;
        seen = 1'b0;
        held = 1'b1;
        overlap = 1'b0;
        while (!seen && cyc < 20) begin
            if (sum16 !== last_sum || cout16 !== last_cout) held = 1'b0;
            @(posedge clk); #1;
            cyc++;
            if (busy16 && done16) overlap = 1'b1;
            if (done16) seen = 1'b1;
        end
    endtask

    task automatic run16(input string name, input logic [15:0] va, input logic [15:0] vb,
                         input logic vc, input logic [15:0] es, input logic ec, input logic eo);
        int cyc;
        logic seen, held, overlap;
        logic [16:0] exp;
        exp_q.push_back({ec, es});
        a16 = va; b16 = vb; cin16 = vc; start16 = 1'b1;
        @(posedge clk); #1;
        start16 = 1'b0;
        a16 = 16'($urandom_range(0, 65535));
        b16 = 16'($urandom_range(0, 65535));
        cin16 = 1'($urandom_range(0, 1));
        chk({name, "_busy"}, 32'(busy16), 32'd1);
        wait_done16(cyc, seen, held, overlap);
        chk({name, "_done_seen"}, 32'(seen), 32'd1);
        chk({name, "_latency"}, 32'(cyc), 32'd4);
        chk({name, "_held"}, 32'(held), 32'd1);
        chk({name, "_busy_done_overlap"}, 32'(overlap), 32'd0);
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : 17'h1ffff;
        chk({name, "_result"}, 32'({cout16, sum16}), 32'(exp));
`ifdef SEQ_ADD_OVF_EN
        chk({name, "_ovf"}, 32'(ovf16), 32'(eo));
`else
        if (eo === 1'bx) $display("unexpected x in ovf vector");
`endif
        last_sum = es;
        last_cout = ec;
        @(posedge clk); #1;
        chk({name, "_done_pulse"}, 32'(done16), 32'd0);
    endtask

    initial begin
        int cyc;
        logic seen, held, overlap;
        int lat_a, lat_b;
        logic [4:0] res_a, res_b, exp5;
        logic ov_a, ov_b, exp_ov4;

        tests = 0;
        failed = 0;
        last_sum = 16'h0000;
        last_cout = 1'b0;

        //            a        b        cin   sum      cout  ovf
        vecs[0] = '{16'h0001, 16'h0002, 1'b0, 16'h0003, 1'b0, 1'b0};
        vecs[1] = '{16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0};
        vecs[2] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
        vecs[3] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
        vecs[4] = '{16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0, 1'b0};
        vecs[5] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0};
        vecs[6] = '{16'h8000, 16'hFFFF, 1'b0, 16'h7FFF, 1'b1, 1'b1};
        vecs[7] = '{16'h0F0F, 16'hF0F0, 1'b1, 16'h0000, 1'b1, 1'b0};
        vecs[8] = '{16'hABCD, 16'h1111, 1'b0, 16'hBCDE, 1'b0, 1'b0};

        start16 = 1'b0; a16 = '0; b16 = '0; cin16 = 1'b0;
        start4 = 1'b0; a4 = '0; b4 = '0; cin4 = 1'b0;
        rst_n = 1'b0;
        #12;
        chk("reset_busy", 32'(busy16), 32'd0);
        chk("reset_done", 32'(done16), 32'd0);
        chk("reset_sum", 32'(sum16), 32'd0);
        chk("reset_cout", 32'(cout16), 32'd0);
        chk("reset_4a", 32'({busy4a, done4a, cout4a, sum4a}), 32'd0);
        chk("reset_4b", 32'({busy4b, done4b, cout4b, sum4b}), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed vector table
        for (int i = 0; i < NV; i++) begin
            run16($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].cin,
                  vecs[i].s, vecs[i].co, vecs[i].ov);
        end

        // Held start with operand change while busy, then back-to-back accept in the done cycle
        a16 = 16'h1111; b16 = 16'h2222; cin16 = 1'b0; start16 = 1'b1;
        @(posedge clk); #1;
        chk("hs_busy1", 32'(busy16), 32'd1);
        a16 = 16'h0F0F; b16 = 16'h0101;
        wait_done16(cyc, seen, held, overlap);
        chk("hs_done1_seen", 32'(seen), 32'd1);
        chk("hs_latency1", 32'(cyc), 32'd4);
        chk("hs_held1", 32'(held), 32'd1);
        chk("hs_sum1", 32'({cout16, sum16}), 32'h0_3333);
        last_sum = 16'h3333; last_cout = 1'b0;
        @(posedge clk); #1;
        start16 = 1'b0;
        chk("hs_b2b_accept", 32'(busy16), 32'd1);
        wait_done16(cyc, seen, held, overlap);
        chk("hs_done2_seen", 32'(seen), 32'd1);
        chk("hs_latency2", 32'(cyc), 32'd4);
        chk("hs_held2", 32'(held), 32'd1);
        chk("hs_sum2", 32'({cout16, sum16}), 32'h0_1010);
        last_sum = 16'h1010; last_cout = 1'b0;
        @(posedge clk); #1;
        chk("hs_no_third", 32'(busy16), 32'd0);

        run16("pre_reset", 16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0);

        // Reset two cycles into a run
        a16 = 16'h1234; b16 = 16'h0001; cin16 = 1'b0; start16 = 1'b1;
        @(posedge clk); #1;
        start16 = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_busy", 32'(busy16), 32'd0);
        chk("rst_mid_done", 32'(done16), 32'd0);
        chk("rst_mid_sum", 32'(sum16), 32'd0);
        chk("rst_mid_cout", 32'(cout16), 32'd0);
`ifdef SEQ_ADD_OVF_EN
        chk("rst_mid_ovf", 32'(ovf16), 32'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (8) begin
            @(posedge clk); #1;
            if (done16 || busy16) seen = 1'b1;
        end
        chk("rst_no_done_after", 32'(seen), 32'd0);
        last_sum = 16'h0000; last_cout = 1'b0;
        run16("post_reset", 16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0);

        // Exhaustive 4-bit sweep: CHUNK=4 (latency 1) and CHUNK=1 (latency 4) side by side
        for (int ia = 0; ia < 16; ia++) begin
            for (int ib = 0; ib < 16; ib++) begin
                for (int ic = 0; ic < 2; ic++) begin
                    a4 = 4'(ia); b4 = 4'(ib); cin4 = 1'(ic); start4 = 1'b1;
                    @(posedge clk); #1;
                    start4 = 1'b0;
                    cyc = 0; lat_a = 0; lat_b = 0;
                    res_a = '1; res_b = '1; ov_a = 1'b0; ov_b = 1'b0;
                    while ((lat_a == 0 || lat_b == 0) && cyc < 10) begin
                        @(posedge clk); #1;
                        cyc++;
                        if (done4a && lat_a == 0) begin
                            lat_a = cyc;
                            res_a = {cout4a, sum4a};
`ifdef SEQ_ADD_OVF_EN
                            ov_a = ovf4a;
`endif
                        end
                        if (done4b && lat_b == 0) begin
                            lat_b = cyc;
                            res_b = {cout4b, sum4b};
`ifdef SEQ_ADD_OVF_EN
                            ov_b = ovf4b;
`endif
                        end
                    end
                    exp5 = 5'(ia + ib + ic);
                    exp_ov4 = (a4[3] == b4[3]) && (exp5[3] != a4[3]);
                    chk($sformatf("sw4_res_a_%0d_%0d_%0d", ia, ib, ic), 32'(res_a), 32'(exp5));
                    chk($sformatf("sw4_lat_a_%0d_%0d_%0d", ia, ib, ic), 32'(lat_a), 32'd1);
                    chk($sformatf("sw1_res_b_%0d_%0d_%0d", ia, ib, ic), 32'(res_b), 32'(exp5));
                    chk($sformatf("sw1_lat_b_%0d_%0d_%0d", ia, ib, ic), 32'(lat_b), 32'd4);
`ifdef SEQ_ADD_OVF_EN
                    chk($sformatf("sw_ovf_%0d_%0d_%0d", ia, ib, ic), 32'({ov_a, ov_b}), 32'({exp_ov4, exp_ov4}));
`else
                    if (ov_a || ov_b || exp_ov4 === 1'bx) $display("unexpected ovf capture");
`endif
                end
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/seq_chunk_adder.md
# seq_chunk_adder

Parametrised multi-cycle adder computing `sum = a + b + cin` over `WIDTH` bits, `CHUNK` bits per clock, least-significant chunk first, with an internal carry register. Successor to the fixed 4-bit combinational adder: arbitrary width, bounded per-cycle carry chain, and a start/busy/done handshake so it can sit on a shared datapath next to other multi-cycle arithmetic units.

## Interface
- `WIDTH`, 16, operand/result width; must be a multiple of `CHUNK`.
- `CHUNK`, 4, bits added per cycle; 1 ≤ `CHUNK` ≤ `WIDTH`. `NCHUNK = WIDTH/CHUNK`.

- `clk`  in  1  clock; all state updates on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  request; sampled only when `busy`=0.
- `a`  in  `WIDTH`  operand A; captured on the accepted `start`.
- `b`  in  `WIDTH`  operand B; captured on the accepted `start`.
- `cin`  in  1  carry-in; captured on the accepted `start`.
- `busy`  out  1  operation in progress.
- `done`  out  1  single-cycle pulse: result valid.
- `sum`  out  `WIDTH`  result register.
- `cout`  out  1  unsigned carry-out of bit `WIDTH-1`.
- `ovf`  out  1  signed overflow; present only with `SEQ_ADD_OVF_EN`.

## Operation
- States: IDLE, RUN.
- IDLE: if `start`=1, latch `a`, `b`, `cin` into operand/carry registers, clear chunk index, set `busy`, go RUN. Otherwise hold.
- RUN: each cycle `{c, s} = a[idx] + b[idx] + carry` (chunk `idx` = bits `idx*CHUNK+CHUNK-1 : idx*CHUNK`, `CHUNK+1`-bit result); write `s` into the working accumulator chunk `idx`, `carry <= c`, `idx <= idx+1`.
- On the cycle processing chunk `NCHUNK-1`: copy accumulator (with the final chunk) to `sum`, final carry to `cout`, pulse `done`, clear `busy`, return to IDLE.
- `sum`/`cout`/`ovf` change only on completion; they hold the previous result throughout RUN and IDLE.
- `start` while `busy`=1 is ignored; operands are not re-sampled.
- Changes on `a`/`b`/`cin` after the accepted `start` have no effect.
- No wrap or saturation: result is modulo 2^`WIDTH`, overflow visible only via `cout`/`ovf`.

## Timing
- Reset (async assert, sync-safe deassert): state IDLE, `busy`=0, `done`=0, `sum`=0, `cout`=0, `ovf`=0, all internal registers 0.
- `start` sampled high at edge k → `busy`=1 after edge k; chunks processed at edges k+1 … k+`NCHUNK`; after edge k+`NCHUNK`: `done`=1, `busy`=0, result valid. Latency `NCHUNK` cycles from accept to `done`.
- `done` is high exactly one cycle; `busy` and `done` never high together.
- Back-to-back: `start`=1 in the `done` cycle is accepted (FSM is IDLE); throughput one result per `NCHUNK`+1 cycles… minimum spacing: new accept at edge k+`NCHUNK`+1.
- Reset mid-RUN: operation abandoned, outputs to reset values immediately, no `done` issued.
- `CHUNK`=`WIDTH`: single RUN cycle, latency 1.

## Configuration
- `SEQ_ADD_OVF_EN` defined: `ovf` port and logic present; `ovf` = (sign of `a` == sign of `b`) and (sign of `sum` ≠ sign of `a`), evaluated on completion, updated with `sum`, reset 0. `cin` participates through `sum`.
- Not defined: `ovf` port and its register absent; all other behaviour identical.

## Test plan
- `WIDTH`=16, `CHUNK`=4: `a`=0x0001, `b`=0x0002, `cin`=0, one-cycle `start` → `busy` 4 cycles, `done` pulse after 4th, `sum`=0x0003, `cout`=0.
- Carry across all chunks: `a`=0xFFFF, `b`=0x0000, `cin`=1 → `sum`=0x0000, `cout`=1, `ovf`=0; `sum` holds prior value until `done`.
- Signed overflow (macro on): `a`=0x7FFF, `b`=0x0001, `cin`=0 → `sum`=0x8000, `cout`=0, `ovf`=1; `a`=0x8000, `b`=0x8000 → `sum`=0x0000, `cout`=1, `ovf`=1.
- Handshake: hold `start`=1 with `a`=0x1111/`b`=0x2222, then change to 0x0F0F/0x0101 while busy → first `done` gives 0x3333; `start` still high in `done` cycle starts second op → 0x1010 four cycles later.
- Reset mid-op: drop `rst_n` 2 cycles after accept → `busy`, `done`, `sum`, `cout` go 0 asynchronously; no `done` after release without new `start`.
- `WIDTH`=4, `CHUNK`=4 and `CHUNK`=1: sweep all 512 `a`/`b`/`cin` combinations → `{cout,sum}` = `a+b+cin` each time, latency 1 and 4 respectively.
